// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, with a sign-fix cycle.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               dvd_neg_q, dvd_neg_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  // Handshake: start is sampled only in IDLE and flush overrides it; busy covers
  // RUN and FIX; done pulses for the single cycle in which HI/LO show the result.
  logic             req, is_md, is_sgn, is_dv, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_add, mul_sum, div_trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign req    = (state_q == S_IDLE) && start && !flush;
  assign is_md  = (op >= 3'd1) && (op <= 3'd4);
  assign is_sgn = (op == 3'd1) || (op == 3'd3);
  assign is_dv  = (op == 3'd3) || (op == 3'd4);
  assign a_neg  = is_sgn && a[WIDTH-1];
  assign b_neg  = is_sgn && b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req && is_md) state_d = S_RUN;
      S_RUN: begin
        if (flush) state_d = S_IDLE;
        else if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  // The accumulator holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    mul_add   = acc_q[0] ? {1'b0, opnd_q} : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_add;
    div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
    prod      = neg_q ? -acc_q : acc_q;
    quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem       = dvd_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    dvd_neg_d = dvd_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && is_md) begin
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, (is_dv ? a_mag : b_mag)};
          opnd_d    = is_dv ? b_mag : a_mag;
          a_raw_d   = a;
          is_div_d  = is_dv;
          neg_d     = a_neg ^ b_neg;
          dvd_neg_d = a_neg;
          dz_d      = is_dv && (b == '0);
        end else if (req && op == 3'd5) begin
          hi_d = a;
        end else if (req && op == 3'd6) begin
          lo_d = a;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!is_div_q) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        else if (div_trial[WIDTH]) acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        else acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
      S_FIX: begin
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      dvd_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      dvd_neg_q <= dvd_neg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32): expected HI/LO pairs are queued at
// issue time and compared when done pulses.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  logic [63:0] exp_q[$];
  logic [31:0] cur_hi, cur_lo;
  logic        prev_done;
  int          n_checks = 0;
  int          n_fail = 0;

  mdu_iter #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from native SV arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] q, r;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd1: return sx * sy;
      3'd2: return {32'h0, x} * {32'h0, y};
      3'd3: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      3'd4: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  // Called at a negedge; leaves start low just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push);
    if (push) exp_q.push_back(model(o, x, y));
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input int exp_busy);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) n++;
    end
    check("done_timeout", seen, 1);
    check("busy_cycles", n, exp_busy);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    issue(o, x, y, 1);
    wait_done(33);
  endtask

  // Scoreboard side: every done must match the oldest queued result.
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse", prev_done, 0);
      check("busy_at_done", busy, 0);
      if (exp_q.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hi_lo", {hi, lo}, e);
        cur_hi = e[63:32];
        cur_lo = e[31:0];
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    start = 1'b0;
    op = 3'd0;
    a = '0;
    b = '0;
    flush = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    prev_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi_lo", {hi, lo}, 64'h0);
    check("rst_busy_done", {busy, done}, 2'b00);
    resetn = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFB, 32'd3);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd4, 32'd7, 32'd0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFF7, 32'd0);

    // Back-to-back: the next start lands in the done cycle.
    @(negedge clk);
    issue(3'd1, 32'd1234, 32'hFFFF_FF00, 1);
    wait_done(33);
    issue(3'd4, 32'hDEAD_0000, 32'd3, 1);
    wait_done(33);

    // mthi in IDLE.
    @(negedge clk);
    issue(3'd5, 32'h1234_5678, 32'd0, 0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_busy_done", {busy, done}, 2'b00);
    cur_hi = 32'h1234_5678;

    // mtlo while busy is ignored; the running result still arrives.
    @(negedge clk);
    issue(3'd1, 32'h0001_0003, 32'h0000_0005, 1);
    repeat (5) @(negedge clk);
    issue(3'd6, 32'hDEAD_BEEF, 32'd0, 0);
    wait_done(28);

    // Flush sampled at iteration 10 of a div.
    @(negedge clk);
    issue(3'd3, 32'hF000_0001, 32'd13, 0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy_done", {busy, done}, 2'b00);
    check("flush_hi_lo", {hi, lo}, {cur_hi, cur_lo});
    repeat (40) @(negedge clk);
    check("flush_keep", {hi, lo}, {cur_hi, cur_lo});

    // Flush coincident with start drops move and mult/div alike.
    @(negedge clk);
    flush = 1'b1;
    issue(3'd5, 32'hAAAA_5555, 32'd0, 0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_mthi", hi, cur_hi);
    flush = 1'b1;
    issue(3'd1, 32'd3, 32'd4, 0);
    flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Reset in the middle of RUN.
    @(negedge clk);
    issue(3'd2, 32'hFFFF_0000, 32'h1234_0000, 0);
    repeat (6) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("rstrun_hi_lo", {hi, lo}, 64'h0);
    check("rstrun_busy_done", {busy, done}, 2'b00);
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    resetn = 1'b1;
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 6; i++) begin
      logic [2:0]  o;
      logic [31:0] x, y;
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      run_op(o, x, y);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
